// File: rtl/hub75_pkg.sv
// Shared constants and types for the HUB75 row capture block.
package hub75_pkg;

   localparam int unsigned COLS_DEF     = 64;
   localparam int unsigned ROW_BITS_DEF = 5;
   localparam int unsigned RGB_W        = 6;
   localparam int unsigned CNT_W        = 8;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_EMIT = 1'b1
   } state_e;

endpackage

// File: rtl/hub75_input_sync.sv
// Two-flop synchronizer plus one delay stage per bit; rise pulse = stage2 & ~stage3.
module hub75_input_sync #(
   parameter int unsigned W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_s2,
   output logic [W-1:0] o_rise_c
);

   logic [W-1:0] s1_q, s2_q, s3_q;
   logic [W-1:0] s1_d, s2_d, s3_d;

   always_comb begin
      s1_d = i_d;
      s2_d = s1_q;
      s3_d = s2_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_q <= RST_VAL;
         s2_q <= RST_VAL;
         s3_q <= RST_VAL;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

   assign o_s2     = s2_q;
   assign o_rise_c = s2_q & ~s3_q;

endmodule

// File: rtl/hub75_row_capture.sv
// Captures HUB75 panel shift traffic into a row buffer and replays it as a
// valid/ready stream of pixel words, flagging malformed rows as sticky errors.
module hub75_row_capture
   import hub75_pkg::*;
#(
   parameter int unsigned COLS     = COLS_DEF,
   parameter int unsigned ROW_BITS = ROW_BITS_DEF
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_data_clock,
   input  logic                i_data_latch,
   input  logic                i_data_blank,
   input  logic [1:0]          i_data_r,
   input  logic [1:0]          i_data_g,
   input  logic [1:0]          i_data_b,
   input  logic [ROW_BITS-1:0] i_row_select,
   output logic                o_px_valid,
   input  logic                i_px_ready,
   output logic [ROW_BITS-1:0] o_px_row,
   output logic [7:0]          o_px_col,
   output logic [RGB_W-1:0]    o_px_rgb,
   output logic                o_row_done,
   output logic                o_err_len,
   output logic                o_err_overrun,
   output logic                o_err_blank,
   input  logic                i_err_clear
);

   localparam int unsigned SYNC_W = ROW_BITS + RGB_W + 3;
   localparam int unsigned IDX_W  = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int unsigned CLK_B  = ROW_BITS + RGB_W;
   localparam int unsigned LAT_B  = ROW_BITS + RGB_W + 1;
   localparam int unsigned BLK_B  = ROW_BITS + RGB_W + 2;
   localparam logic [SYNC_W-1:0] SYNC_RST = {1'b1, {(SYNC_W-1){1'b0}}};

   logic [SYNC_W-1:0]   sync_in;
   logic [SYNC_W-1:0]   sync_s2;
   logic [SYNC_W-1:0]   sync_rise_c;
   logic [ROW_BITS-1:0] row_s2;
   logic [RGB_W-1:0]    rgb_s2;
   logic                shift_rise_c;
   logic                latch_rise_c;
   logic                blank_s2;
   logic                unused_sync;

   // Blank sits in the MSB so it resets to the blanked level.
   assign sync_in = {i_data_blank, i_data_latch, i_data_clock,
                     i_data_r, i_data_g, i_data_b, i_row_select};

   hub75_input_sync #(
      .W       (SYNC_W),
      .RST_VAL (SYNC_RST)
   ) u_sync (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_d      (sync_in),
      .o_s2     (sync_s2),
      .o_rise_c (sync_rise_c)
   );

   assign row_s2       = sync_s2[ROW_BITS-1:0];
   assign rgb_s2       = sync_s2[ROW_BITS +: RGB_W];
   assign blank_s2     = sync_s2[BLK_B];
   assign shift_rise_c = sync_rise_c[CLK_B];
   assign latch_rise_c = sync_rise_c[LAT_B];
   assign unused_sync  = ^{sync_rise_c[BLK_B], sync_rise_c[CLK_B-1:0], sync_s2[LAT_B:CLK_B]};

   state_e                       state_q, state_d;
   logic [COLS-1:0][RGB_W-1:0]   sr_q, sr_d;
   logic [COLS-1:0][RGB_W-1:0]   buf_q, buf_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic                         valid_q, valid_d;
   logic [ROW_BITS-1:0]          row_q, row_d;
   logic [7:0]                   col_q, col_d;
   logic [RGB_W-1:0]             rgb_q, rgb_d;
   logic                         done_q, done_d;
   logic                         err_len_q, err_len_d;
   logic                         err_ovr_q, err_ovr_d;
   logic                         err_blk_q, err_blk_d;
   logic [7:0]                   col_nxt;
   logic                         accept_c;

   assign accept_c = valid_q & i_px_ready;
   assign col_nxt  = col_q + 8'd1;

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      buf_d     = buf_q;
      cnt_d     = cnt_q;
      valid_d   = valid_q;
      row_d     = row_q;
      col_d     = col_q;
      rgb_d     = rgb_q;
      done_d    = 1'b0;
      err_len_d = err_len_q & ~i_err_clear;
      err_ovr_d = err_ovr_q & ~i_err_clear;
      err_blk_d = err_blk_q & ~i_err_clear;

      // New pixels enter column 0 and migrate upward, so pixel k ends in COLS-1-k.
      if (shift_rise_c) begin
         sr_d = {sr_q[COLS-2:0], rgb_s2};
      end

      // A shift coinciding with a latch belongs to the following row.
      if (latch_rise_c) begin
         cnt_d = shift_rise_c ? CNT_W'(1) : CNT_W'(0);
      end else if (shift_rise_c && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      if (latch_rise_c && !blank_s2) begin
         err_blk_d = 1'b1;
      end

      unique case (state_q)
         S_IDLE: begin
            if (latch_rise_c) begin
               if (cnt_q == CNT_W'(COLS)) begin
                  buf_d   = sr_q;
                  row_d   = row_s2;
                  col_d   = 8'd0;
                  rgb_d   = sr_q[0];
                  valid_d = 1'b1;
                  state_d = S_EMIT;
               end else begin
                  err_len_d = 1'b1;
               end
            end
         end
         S_EMIT: begin
            if (latch_rise_c) begin
               err_ovr_d = 1'b1;
            end
            if (accept_c) begin
               if (col_q == 8'(COLS - 1)) begin
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  col_d = col_nxt;
                  rgb_d = buf_q[IDX_W'(col_nxt)];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sr_q      <= '0;
         buf_q     <= '0;
         cnt_q     <= '0;
         valid_q   <= 1'b0;
         row_q     <= '0;
         col_q     <= '0;
         rgb_q     <= '0;
         done_q    <= 1'b0;
         err_len_q <= 1'b0;
         err_ovr_q <= 1'b0;
         err_blk_q <= 1'b0;
      end else begin
         sr_q      <= sr_d;
         buf_q     <= buf_d;
         cnt_q     <= cnt_d;
         valid_q   <= valid_d;
         row_q     <= row_d;
         col_q     <= col_d;
         rgb_q     <= rgb_d;
         done_q    <= done_d;
         err_len_q <= err_len_d;
         err_ovr_q <= err_ovr_d;
         err_blk_q <= err_blk_d;
      end
   end

   assign o_px_valid    = valid_q;
   assign o_px_row      = row_q;
   assign o_px_col      = col_q;
   assign o_px_rgb      = rgb_q;
   assign o_row_done    = done_q;
   assign o_err_len     = err_len_q;
   assign o_err_overrun = err_ovr_q;
   assign o_err_blank   = err_blk_q;

endmodule
